// File: rtl/pipeline_stall_controller_pkg.sv
// pipeline_stall_controller_pkg: shared state encodings and control-bundle type for the stall controller.
package pipeline_stall_controller_pkg;

    localparam int CTRL_STATE_W = 2;

    typedef enum logic [CTRL_STATE_W-1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MD_BUSY  = 2'd2,
        ST_MEM_WAIT = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic ex_mem_bubble;
        logic mem_wb_write;
    } ctrl_t;

    // Bit order follows ctrl_t: pc, if_id_w, flush, id_ex_bub, ex_mem_w, ex_mem_bub, mem_wb_w
    localparam ctrl_t CTRL_HOLD     = 7'b0000000;
    localparam ctrl_t CTRL_INIT     = 7'b0010000;
    localparam ctrl_t CTRL_RUN      = 7'b1100101;
    localparam ctrl_t CTRL_HAZ      = 7'b0001101;
    localparam ctrl_t CTRL_MD       = 7'b0000011;
    localparam ctrl_t CTRL_REDIRECT = 7'b1110101;

endpackage

// File: rtl/pipeline_stall_controller_md_watchdog.sv
// md_watchdog: saturating mul/div occupancy counter with a sticky timeout error.
module md_watchdog #(
    parameter int MD_TIMEOUT = 64,
    parameter int MD_CNT_W   = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy,
    output logic timeout,
    output logic err
);
    logic [MD_CNT_W-1:0] cnt;

    // Fires on the last allowed busy cycle so the exit and the error land on the same edge
    assign timeout = busy && (cnt == MD_CNT_W'(MD_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= (!busy || timeout) ? '0 : (&cnt) ? cnt : cnt + MD_CNT_W'(1);
            err <= err | timeout;
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: merges hazard, redirect, mul/div and memory stalls into per-stage enables.
// Optional STALL_PERF_CNT_EN adds saturating per-cause stall-cycle counters.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int MD_CNT_W   = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hazard_stall,
    input  logic                    branch_taken,
    input  logic                    imem_ready,
    input  logic                    dmem_req,
    input  logic                    dmem_ready,
    input  logic                    md_start,
    input  logic                    md_done,
    output logic                    pc_write,
    output logic                    if_id_write,
    output logic                    if_id_flush,
    output logic                    id_ex_bubble,
    output logic                    ex_mem_write,
    output logic                    ex_mem_bubble,
    output logic                    mem_wb_write,
    output logic                    md_timeout_err,
    output logic [CTRL_STATE_W-1:0] ctrl_state
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0]             perf_hazard_cycles,
    output logic [31:0]             perf_md_cycles,
    output logic [31:0]             perf_mem_cycles
`endif
);
    state_t state, state_nx;
    ctrl_t  ctrl;
    logic   redirect_pending, md_timeout;
    logic   run_like, dmem_wait, md_start_eff, mem_win, md_win, hz_win, rd_win;

    // The releasing cycle of MEM_WAIT or MD_BUSY is decoded exactly like RUN
    assign run_like     = (state == ST_RUN) || (state == ST_MEM_WAIT && dmem_ready) || (state == ST_MD_BUSY && md_done);
    assign dmem_wait    = dmem_req && !dmem_ready;
    assign md_start_eff = md_start && state != ST_MD_BUSY;
    assign mem_win      = (run_like && (dmem_wait || !imem_ready)) || (state == ST_MEM_WAIT && !dmem_ready);
    assign md_win       = !mem_win && ((run_like && md_start_eff && !md_done) || (state == ST_MD_BUSY && !md_done));
    assign hz_win       = run_like && !mem_win && !md_win && hazard_stall;
    assign rd_win       = run_like && !mem_win && !md_win && !hazard_stall && (branch_taken || redirect_pending);

    always_comb begin
        ctrl = state == ST_INIT ? CTRL_INIT : mem_win ? CTRL_HOLD : md_win ? CTRL_MD :
               hz_win ? CTRL_HAZ : rd_win ? CTRL_REDIRECT : CTRL_RUN;
        if (!rst_n) ctrl = CTRL_HOLD;
    end

    always_comb begin
        state_nx = state == ST_INIT ? ST_RUN :
                   run_like ? (dmem_wait ? ST_MEM_WAIT : md_win ? ST_MD_BUSY : ST_RUN) :
                   (state == ST_MD_BUSY && md_timeout) ? ST_RUN : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_INIT;
            redirect_pending <= 1'b0;
        end else begin
            state            <= state_nx;
            redirect_pending <= (redirect_pending || (branch_taken && (mem_win || md_win))) && !ctrl.if_id_flush;
        end
    end

    md_watchdog #(.MD_TIMEOUT(MD_TIMEOUT), .MD_CNT_W(MD_CNT_W)) u_md_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .busy   (state == ST_MD_BUSY && !md_done),
        .timeout(md_timeout),
        .err    (md_timeout_err)
    );

    assign pc_write      = ctrl.pc_write;
    assign if_id_write   = ctrl.if_id_write;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_bubble  = ctrl.id_ex_bubble;
    assign ex_mem_write  = ctrl.ex_mem_write;
    assign ex_mem_bubble = ctrl.ex_mem_bubble;
    assign mem_wb_write  = ctrl.mem_wb_write;
    assign ctrl_state    = state;

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hazard_cycles <= '0;
            perf_md_cycles     <= '0;
            perf_mem_cycles    <= '0;
        end else begin
            if (hz_win && perf_hazard_cycles != '1) perf_hazard_cycles <= perf_hazard_cycles + 32'd1;
            if (md_win && perf_md_cycles != '1) perf_md_cycles <= perf_md_cycles + 32'd1;
            if (mem_win && perf_mem_cycles != '1) perf_mem_cycles <= perf_mem_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed checks of the stall controller, default and short-timeout builds.
module tb_pipeline_stall_controller;

    localparam logic [6:0] E_HOLD = 7'b0000000;
    localparam logic [6:0] E_INIT = 7'b0010000;
    localparam logic [6:0] E_RUN  = 7'b1100101;
    localparam logic [6:0] E_HAZ  = 7'b0001101;
    localparam logic [6:0] E_MD   = 7'b0000011;
    localparam logic [6:0] E_RED  = 7'b1110101;

    logic clk = 1'b0, rst_n = 1'b0;
    logic hazard_stall = 1'b0, branch_taken = 1'b0, imem_ready = 1'b1;
    logic dmem_req = 1'b0, dmem_ready = 1'b0, md_start = 1'b0, md_done = 1'b0;
    logic pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, ex_mem_bubble, mem_wb_write, md_timeout_err;
    logic [1:0] ctrl_state;
    logic t_pc, t_ifw, t_fl, t_idb, t_exw, t_exb, t_wbw, t_err;
    logic [1:0] t_state;
    logic [6:0] ctl, t_ctl;
    int n_checks = 0, n_fails = 0;

    assign ctl   = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, ex_mem_bubble, mem_wb_write};
    assign t_ctl = {t_pc, t_ifw, t_fl, t_idb, t_exw, t_exb, t_wbw};

    always #5 clk = ~clk;

    pipeline_stall_controller dut (
        .clk(clk), .rst_n(rst_n), .hazard_stall(hazard_stall), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .md_start(md_start), .md_done(md_done), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write),
        .ex_mem_bubble(ex_mem_bubble), .mem_wb_write(mem_wb_write),
        .md_timeout_err(md_timeout_err), .ctrl_state(ctrl_state)
    );

    pipeline_stall_controller #(.MD_TIMEOUT(4), .MD_CNT_W(3)) dut_to (
        .clk(clk), .rst_n(rst_n), .hazard_stall(hazard_stall), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .md_start(md_start), .md_done(md_done), .pc_write(t_pc), .if_id_write(t_ifw),
        .if_id_flush(t_fl), .id_ex_bubble(t_idb), .ex_mem_write(t_exw),
        .ex_mem_bubble(t_exb), .mem_wb_write(t_wbw),
        .md_timeout_err(t_err), .ctrl_state(t_state)
    );

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (ctl !== E_HOLD) begin n_fails++; $display("FAIL rst_ctl got=%b exp=%b", ctl, E_HOLD); end
        n_checks++; if (ctrl_state !== 2'd0) begin n_fails++; $display("FAIL rst_state got=%0d exp=0", ctrl_state); end
        n_checks++; if (md_timeout_err !== 1'b0) begin n_fails++; $display("FAIL rst_err got=%b exp=0", md_timeout_err); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (ctl !== E_INIT) begin n_fails++; $display("FAIL init_ctl got=%b exp=%b", ctl, E_INIT); end
        n_checks++; if (ctrl_state !== 2'd0) begin n_fails++; $display("FAIL init_state got=%0d exp=0", ctrl_state); end
        @(negedge clk); #1;
        n_checks++; if (ctl !== E_RUN) begin n_fails++; $display("FAIL run_ctl got=%b exp=%b", ctl, E_RUN); end
        n_checks++; if (ctrl_state !== 2'd1) begin n_fails++; $display("FAIL run_state got=%0d exp=1", ctrl_state); end
    endtask

    task automatic test_hazard_branch;
        @(negedge clk); hazard_stall = 1'b1; branch_taken = 1'b1; #1;
        n_checks++; if (ctl !== E_HAZ) begin n_fails++; $display("FAIL hz_ctl got=%b exp=%b", ctl, E_HAZ); end
        n_checks++; if (ctrl_state !== 2'd1) begin n_fails++; $display("FAIL hz_state got=%0d exp=1", ctrl_state); end
        @(negedge clk); hazard_stall = 1'b0; branch_taken = 1'b0; #1;
        n_checks++; if (ctl !== E_RUN) begin n_fails++; $display("FAIL hz_after got=%b exp=%b", ctl, E_RUN); end
        @(negedge clk); branch_taken = 1'b1; #1;
        n_checks++; if (ctl !== E_RED) begin n_fails++; $display("FAIL br_ctl got=%b exp=%b", ctl, E_RED); end
        @(negedge clk); branch_taken = 1'b0; #1;
        n_checks++; if (ctl !== E_RUN) begin n_fails++; $display("FAIL br_after got=%b exp=%b", ctl, E_RUN); end
    endtask

    task automatic test_md_done;
        @(negedge clk); md_start = 1'b1; #1;
        n_checks++; if (ctl !== E_MD) begin n_fails++; $display("FAIL md_first got=%b exp=%b", ctl, E_MD); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_checks++; if (ctrl_state !== 2'd2 || ctl !== E_MD) begin
                n_fails++; $display("FAIL md_busy%0d got=%0d/%b exp=2/%b", i, ctrl_state, ctl, E_MD);
            end
        end
        @(negedge clk); md_done = 1'b1; #1;
        n_checks++; if (ctrl_state !== 2'd2 || ctl !== E_RUN) begin
            n_fails++; $display("FAIL md_done_cyc got=%0d/%b exp=2/%b", ctrl_state, ctl, E_RUN);
        end
        @(negedge clk); md_start = 1'b0; md_done = 1'b0; #1;
        n_checks++; if (ctrl_state !== 2'd1 || ctl !== E_RUN) begin
            n_fails++; $display("FAIL md_back got=%0d/%b exp=1/%b", ctrl_state, ctl, E_RUN);
        end
        n_checks++; if (md_timeout_err !== 1'b0) begin n_fails++; $display("FAIL md_err got=%b exp=0", md_timeout_err); end
    endtask

    task automatic test_timeout;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); md_start = 1'b1; #1;
        n_checks++; if (t_state !== 2'd1 || t_ctl !== E_MD) begin
            n_fails++; $display("FAIL to_start got=%0d/%b exp=1/%b", t_state, t_ctl, E_MD);
        end
        @(negedge clk); md_start = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        #1;
        n_checks++; if (t_state !== 2'd2 || t_err !== 1'b0) begin
            n_fails++; $display("FAIL to_last got=%0d/%b exp=2/0", t_state, t_err);
        end
        @(negedge clk); #1;
        n_checks++; if (t_state !== 2'd1 || t_err !== 1'b1) begin
            n_fails++; $display("FAIL to_fire got=%0d/%b exp=1/1", t_state, t_err);
        end
        n_checks++; if (ctrl_state !== 2'd2 || md_timeout_err !== 1'b0) begin
            n_fails++; $display("FAIL to_default got=%0d/%b exp=2/0", ctrl_state, md_timeout_err);
        end
        @(negedge clk); md_done = 1'b1;
        @(negedge clk); md_done = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (t_err !== 1'b1 || t_ctl !== E_RUN) begin
            n_fails++; $display("FAIL to_sticky got=%b/%b exp=1/%b", t_err, t_ctl, E_RUN);
        end
        rst_n = 1'b0; #1;
        n_checks++; if (t_err !== 1'b0) begin n_fails++; $display("FAIL to_clear got=%b exp=0", t_err); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mem_wait_redirect;
        @(negedge clk); dmem_req = 1'b1; dmem_ready = 1'b0; #1;
        n_checks++; if (ctl !== E_HOLD || ctrl_state !== 2'd1) begin
            n_fails++; $display("FAIL mw1 got=%b/%0d exp=%b/1", ctl, ctrl_state, E_HOLD);
        end
        @(negedge clk); branch_taken = 1'b1; #1;
        n_checks++; if (ctl !== E_HOLD || ctrl_state !== 2'd3) begin
            n_fails++; $display("FAIL mw2 got=%b/%0d exp=%b/3", ctl, ctrl_state, E_HOLD);
        end
        @(negedge clk); branch_taken = 1'b0; #1;
        n_checks++; if (ctl !== E_HOLD || ctrl_state !== 2'd3) begin
            n_fails++; $display("FAIL mw3 got=%b/%0d exp=%b/3", ctl, ctrl_state, E_HOLD);
        end
        @(negedge clk); dmem_ready = 1'b1; #1;
        n_checks++; if (ctl !== E_RED) begin n_fails++; $display("FAIL mw_release got=%b exp=%b", ctl, E_RED); end
        @(negedge clk); dmem_req = 1'b0; dmem_ready = 1'b0; #1;
        n_checks++; if (ctl !== E_RUN || ctrl_state !== 2'd1) begin
            n_fails++; $display("FAIL mw_after got=%b/%0d exp=%b/1", ctl, ctrl_state, E_RUN);
        end
    endtask

    task automatic test_imem_and_md_mem;
        @(negedge clk); imem_ready = 1'b0; md_start = 1'b1; #1;
        n_checks++; if (ctl !== E_HOLD) begin n_fails++; $display("FAIL imem_ctl got=%b exp=%b", ctl, E_HOLD); end
        @(negedge clk); imem_ready = 1'b1; md_start = 1'b0; #1;
        n_checks++; if (ctrl_state !== 2'd1 || ctl !== E_RUN) begin
            n_fails++; $display("FAIL imem_stay got=%0d/%b exp=1/%b", ctrl_state, ctl, E_RUN);
        end
        @(negedge clk); dmem_req = 1'b1; md_start = 1'b1; #1;
        n_checks++; if (ctl !== E_HOLD) begin n_fails++; $display("FAIL mdmem1 got=%b exp=%b", ctl, E_HOLD); end
        @(negedge clk); dmem_ready = 1'b1; #1;
        n_checks++; if (ctrl_state !== 2'd3 || ctl !== E_MD) begin
            n_fails++; $display("FAIL mdmem2 got=%0d/%b exp=3/%b", ctrl_state, ctl, E_MD);
        end
        @(negedge clk); dmem_req = 1'b0; dmem_ready = 1'b0; #1;
        n_checks++; if (ctrl_state !== 2'd2 || ctl !== E_MD) begin
            n_fails++; $display("FAIL mdmem3 got=%0d/%b exp=2/%b", ctrl_state, ctl, E_MD);
        end
        @(negedge clk); md_done = 1'b1; md_start = 1'b0; #1;
        n_checks++; if (ctl !== E_RUN) begin n_fails++; $display("FAIL mdmem4 got=%b exp=%b", ctl, E_RUN); end
        @(negedge clk); md_done = 1'b0; #1;
        n_checks++; if (ctrl_state !== 2'd1) begin n_fails++; $display("FAIL mdmem5 got=%0d exp=1", ctrl_state); end
    endtask

    task automatic test_async_reset;
        @(negedge clk); md_start = 1'b1;
        @(negedge clk); md_start = 1'b0; #1;
        n_checks++; if (ctrl_state !== 2'd2) begin n_fails++; $display("FAIL ar_busy got=%0d exp=2", ctrl_state); end
        rst_n = 1'b0; #1;
        n_checks++; if (ctl !== E_HOLD || ctrl_state !== 2'd0) begin
            n_fails++; $display("FAIL ar_drop got=%b/%0d exp=%b/0", ctl, ctrl_state, E_HOLD);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_hazard_branch();
        test_md_done();
        test_timeout();
        test_mem_wait_redirect();
        test_imem_and_md_mem();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
